// File: rtl/collector_pkg.sv
// Shared definitions for the data-collector write path: FSM states, data widths
// and the default pad byte.
package collector_pkg;

   localparam int WORD_W = 16;
   localparam int BYTE_W = 8;

   localparam logic [BYTE_W-1:0] DEFAULT_PAD_BYTE = 8'h00;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      STROBE  = 2'd1,
      RECOVER = 2'd2
   } wr_state_t;

endpackage

// File: rtl/pack_word_queue.sv
// Small word queue between the byte packer and the FIFO write FSM. Push and pop
// in the same cycle are both honoured, even when the queue is full.
module pack_word_queue
   import collector_pkg::*;
#(
   parameter int QUEUE_DEPTH = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  logic [WORD_W-1:0] push_data,
   input  logic              pop,
   output logic [WORD_W-1:0] head,
   output logic              empty,
   output logic              full
);

   localparam int AW = $clog2(QUEUE_DEPTH);

   // The extra pointer bit separates the full case from the empty case.
   logic [AW:0]       wptr;
   logic [AW:0]       rptr;
   logic [WORD_W-1:0] mem [QUEUE_DEPTH];
   logic              do_push;
   logic              do_pop;

   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rptr[AW-1:0]];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + {{AW{1'b0}}, 1'b1};
         if (do_pop)  rptr <= rptr + {{AW{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/fifo_pack_writer.sv
// Packs a byte stream MSB-first into 16-bit words and feeds them to the
// collector FIFO as one-cycle WR_EN pulses with DIN held stable.
module fifo_pack_writer
   import collector_pkg::*;
#(
   parameter logic [BYTE_W-1:0] PAD_BYTE    = DEFAULT_PAD_BYTE,
   parameter int                QUEUE_DEPTH = 4
) (
   input  logic              WR_CLK,
   input  logic              reset,
   input  logic [BYTE_W-1:0] BYTE_IN,
   input  logic              BYTE_VALID,
   input  logic              FLUSH,
   input  logic              CLR_ERR,
   input  logic              FULL,
   output logic [WORD_W-1:0] DIN,
   output logic              WR_EN,
   output logic              BUSY,
   output logic              OVERFLOW,
   output logic [WORD_W-1:0] WORD_COUNT
);

   wr_state_t         state;
   wr_state_t         state_nxt;
   logic              half;
   logic              half_nxt;
   logic [BYTE_W-1:0] hi_byte;
   logic [BYTE_W-1:0] hi_nxt;
   logic              push;
   logic [WORD_W-1:0] push_data;
   logic              start;
   logic              drop;
   logic [WORD_W-1:0] q_head;
   logic              q_empty;
   logic              q_full;

   pack_word_queue #(.QUEUE_DEPTH(QUEUE_DEPTH)) u_queue (
      .clock     (WR_CLK),
      .reset     (reset),
      .push      (push),
      .push_data (push_data),
      .pop       (start),
      .head      (q_head),
      .empty     (q_empty),
      .full      (q_full)
   );

   // A byte arriving with FLUSH is taken first; a lone first byte is padded.
   always_comb begin
      push      = 1'b0;
      push_data = {hi_byte, BYTE_IN};
      half_nxt  = half;
      hi_nxt    = hi_byte;
      if (BYTE_VALID) begin
         if (half) begin
            push     = 1'b1;
            half_nxt = 1'b0;
         end else if (FLUSH) begin
            push      = 1'b1;
            push_data = {BYTE_IN, PAD_BYTE};
         end else begin
            hi_nxt   = BYTE_IN;
            half_nxt = 1'b1;
         end
      end else if (FLUSH && half) begin
         push      = 1'b1;
         push_data = {hi_byte, PAD_BYTE};
         half_nxt  = 1'b0;
      end
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      case (state)
         IDLE, RECOVER: begin
            if (!q_empty && !FULL) begin
               start     = 1'b1;
               state_nxt = STROBE;
            end else begin
               state_nxt = IDLE;
            end
         end
         STROBE:  state_nxt = RECOVER;
         default: state_nxt = IDLE;
      endcase
   end

   assign drop = push && q_full && !start;
   assign BUSY = half || !q_empty || (state != IDLE);

   always_ff @(posedge WR_CLK or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge WR_CLK or negedge reset) begin
      if (!reset) begin
         half       <= 1'b0;
         hi_byte    <= '0;
         DIN        <= '0;
         WR_EN      <= 1'b0;
         OVERFLOW   <= 1'b0;
         WORD_COUNT <= '0;
      end else begin
         half    <= half_nxt;
         hi_byte <= hi_nxt;
         WR_EN   <= start;
         if (start) begin
            DIN        <= q_head;
            WORD_COUNT <= WORD_COUNT + 16'd1;
         end
         if (drop)         OVERFLOW <= 1'b1;
         else if (CLR_ERR) OVERFLOW <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fifo_pack_writer.sv
// Directed bench for fifo_pack_writer: a per-cycle vector table for the basic
// packing/flush behaviour plus hand-written overflow, streaming, wrap and reset sequences.
module tb_fifo_pack_writer;

   logic        WR_CLK = 1'b0;
   logic        reset;
   logic [7:0]  BYTE_IN;
   logic        BYTE_VALID;
   logic        FLUSH;
   logic        CLR_ERR;
   logic        FULL;
   logic [15:0] DIN;
   logic        WR_EN;
   logic        BUSY;
   logic        OVERFLOW;
   logic [15:0] WORD_COUNT;

   fifo_pack_writer #(.PAD_BYTE(8'h00), .QUEUE_DEPTH(4)) dut (
      .WR_CLK     (WR_CLK),
      .reset      (reset),
      .BYTE_IN    (BYTE_IN),
      .BYTE_VALID (BYTE_VALID),
      .FLUSH      (FLUSH),
      .CLR_ERR    (CLR_ERR),
      .FULL       (FULL),
      .DIN        (DIN),
      .WR_EN      (WR_EN),
      .BUSY       (BUSY),
      .OVERFLOW   (OVERFLOW),
      .WORD_COUNT (WORD_COUNT)
   );

   always #5 WR_CLK = ~WR_CLK;

   typedef struct {
      logic [7:0]  b;
      logic        v;
      logic        f;
      logic [15:0] din;
      logic        wr;
      logic        busy;
      logic [15:0] cnt;
   } vec_t;

   vec_t        tbl[$];
   logic [15:0] exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic void add(input logic [7:0] b, input logic v, input logic f,
                               input logic [15:0] din, input logic wr, input logic busy,
                               input logic [15:0] cnt);
      vec_t r;
      r.b = b; r.v = v; r.f = f; r.din = din; r.wr = wr; r.busy = busy; r.cnt = cnt;
      tbl.push_back(r);
   endfunction

   task automatic tick();
      @(posedge WR_CLK);
      #1;
   endtask

   task automatic set_in(input logic [7:0] b, input logic v, input logic f);
      BYTE_IN    = b;
      BYTE_VALID = v;
      FLUSH      = f;
   endtask

   // Drain with FULL=0 and compare every strobed word against exp_q in order.
   task automatic drain(input string name, input int cycles);
      int seen;
      seen = 0;
      FULL = 1'b0;
      for (int c = 0; c < cycles; c++) begin
         tick();
         if (WR_EN) begin
            if (exp_q.size() > 0) check({name, "_din"}, 32'(DIN), 32'(exp_q.pop_front()));
            seen++;
         end
      end
      check({name, "_pulses"}, 32'(seen), 32'd4);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   pulses;
      int   last;
      int   p2;
      logic seen_wr;
      logic [15:0] expw;

      reset = 1'b0;
      set_in(8'h00, 1'b0, 1'b0);
      CLR_ERR = 1'b0;
      FULL    = 1'b0;
      repeat (2) @(posedge WR_CLK);
      #1;
      check("rst_din",   32'(DIN), 32'h0);
      check("rst_wr",    32'(WR_EN), 32'd0);
      check("rst_busy",  32'(BUSY), 32'd0);
      check("rst_ovf",   32'(OVERFLOW), 32'd0);
      check("rst_count", 32'(WORD_COUNT), 32'd0);
      @(negedge WR_CLK);
      reset = 1'b1;

      // byte, valid, flush | DIN, WR_EN, BUSY, WORD_COUNT after the edge
      add(8'h12, 1, 0, 16'h0000, 0, 1, 16'd0);
      add(8'h34, 1, 0, 16'h0000, 0, 1, 16'd0);
      add(8'h00, 0, 0, 16'h1234, 1, 1, 16'd1);
      add(8'h00, 0, 0, 16'h1234, 0, 1, 16'd1);
      add(8'h00, 0, 0, 16'h1234, 0, 0, 16'd1);
      add(8'hAB, 1, 0, 16'h1234, 0, 1, 16'd1);
      add(8'h00, 0, 1, 16'h1234, 0, 1, 16'd1);
      add(8'h00, 0, 0, 16'hAB00, 1, 1, 16'd2);
      add(8'h00, 0, 1, 16'hAB00, 0, 1, 16'd2);
      add(8'h00, 0, 0, 16'hAB00, 0, 0, 16'd2);
      add(8'h00, 0, 0, 16'hAB00, 0, 0, 16'd2);
      add(8'h77, 1, 1, 16'hAB00, 0, 1, 16'd2);
      add(8'h00, 0, 0, 16'h7700, 1, 1, 16'd3);
      add(8'h88, 1, 0, 16'h7700, 0, 1, 16'd3);
      add(8'h99, 1, 1, 16'h7700, 0, 1, 16'd3);
      add(8'h00, 0, 0, 16'h8899, 1, 1, 16'd4);
      add(8'h00, 0, 0, 16'h8899, 0, 1, 16'd4);
      add(8'h00, 0, 0, 16'h8899, 0, 0, 16'd4);

      for (int i = 0; i < tbl.size(); i++) begin
         set_in(tbl[i].b, tbl[i].v, tbl[i].f);
         tick();
         check($sformatf("vec%0d_din", i),   32'(DIN), 32'(tbl[i].din));
         check($sformatf("vec%0d_wr", i),    32'(WR_EN), 32'(tbl[i].wr));
         check($sformatf("vec%0d_busy", i),  32'(BUSY), 32'(tbl[i].busy));
         check($sformatf("vec%0d_count", i), 32'(WORD_COUNT), 32'(tbl[i].cnt));
      end
      set_in(8'h00, 1'b0, 1'b0);

      // FIFO full: four words queue up, the fifth is dropped
      FULL = 1'b1;
      seen_wr = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         set_in(8'(i), 1'b1, 1'b0);
         tick();
         seen_wr |= WR_EN;
         if (i == 9)  check("ovf_before_drop", 32'(OVERFLOW), 32'd0);
         if (i == 10) check("ovf_on_drop", 32'(OVERFLOW), 32'd1);
      end
      set_in(8'h00, 1'b0, 1'b0);
      check("no_wr_while_full", 32'(seen_wr), 32'd0);
      exp_q = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
      drain("ovf_drain", 16);
      check("ovf_count", 32'(WORD_COUNT), 32'd8);
      check("ovf_sticky", 32'(OVERFLOW), 32'd1);
      CLR_ERR = 1'b1;
      tick();
      CLR_ERR = 1'b0;
      check("ovf_cleared", 32'(OVERFLOW), 32'd0);

      // CLR_ERR on the same cycle as a new drop: set wins
      FULL = 1'b1;
      for (int i = 0; i < 10; i++) begin
         set_in(8'h20 + 8'(i), 1'b1, 1'b0);
         CLR_ERR = (i == 9);
         tick();
      end
      set_in(8'h00, 1'b0, 1'b0);
      CLR_ERR = 1'b0;
      check("ovf_set_wins", 32'(OVERFLOW), 32'd1);
      exp_q = '{16'h2021, 16'h2223, 16'h2425, 16'h2627};
      drain("setwins_drain", 16);
      CLR_ERR = 1'b1;
      tick();
      CLR_ERR = 1'b0;
      check("ovf_cleared2", 32'(OVERFLOW), 32'd0);
      check("count_12", 32'(WORD_COUNT), 32'd12);

      // continuous stream of 256 bytes
      pulses = 0;
      last   = -1;
      for (int cyc = 0; cyc < 266; cyc++) begin
         if (cyc < 256) set_in(8'(cyc), 1'b1, 1'b0);
         else           set_in(8'h00, 1'b0, 1'b0);
         tick();
         if (WR_EN) begin
            p2   = 2 * pulses;
            expw = {p2[7:0], p2[7:0] + 8'd1};
            check($sformatf("stream%0d_din", pulses), 32'(DIN), 32'(expw));
            if (pulses > 0) check($sformatf("stream%0d_gap", pulses), 32'(cyc - last), 32'd2);
            last = cyc;
            pulses++;
         end
      end
      check("stream_pulses", 32'(pulses), 32'd128);
      check("stream_ovf", 32'(OVERFLOW), 32'd0);
      check("stream_count", 32'(WORD_COUNT), 32'd140);
      check("stream_idle", 32'(BUSY), 32'd0);

      // preload the counter just below wrap, then write two words
      force dut.WORD_COUNT = 16'hFFFE;
      @(negedge WR_CLK);
      release dut.WORD_COUNT;
      tick();
      for (int i = 0; i < 4; i++) begin
         set_in(8'hC0 + 8'(i), 1'b1, 1'b0);
         tick();
      end
      set_in(8'h00, 1'b0, 1'b0);
      repeat (4) tick();
      check("wrap_count", 32'(WORD_COUNT), 32'h0000);
      check("wrap_din", 32'(DIN), 32'hC2C3);

      // reset while strobing, with a half word pending
      set_in(8'h11, 1'b1, 1'b0); tick();
      set_in(8'h22, 1'b1, 1'b0); tick();
      set_in(8'h33, 1'b1, 1'b0); tick();
      set_in(8'h00, 1'b0, 1'b0);
      check("pre_reset_wr", 32'(WR_EN), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("async_rst_wr",    32'(WR_EN), 32'd0);
      check("async_rst_din",   32'(DIN), 32'h0);
      check("async_rst_busy",  32'(BUSY), 32'd0);
      check("async_rst_ovf",   32'(OVERFLOW), 32'd0);
      check("async_rst_count", 32'(WORD_COUNT), 32'd0);
      @(negedge WR_CLK);
      reset = 1'b1;
      seen_wr = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         seen_wr |= WR_EN;
      end
      check("post_rst_no_wr", 32'(seen_wr), 32'd0);
      check("post_rst_busy", 32'(BUSY), 32'd0);
      set_in(8'h55, 1'b1, 1'b0); tick();
      set_in(8'h66, 1'b1, 1'b0); tick();
      set_in(8'h00, 1'b0, 1'b0);
      seen_wr = 1'b0;
      for (int i = 0; i < 10 && !seen_wr; i++) begin
         tick();
         seen_wr = WR_EN;
      end
      check("post_rst_strobe", 32'(seen_wr), 32'd1);
      check("post_rst_din", 32'(DIN), 32'h5566);
      check("post_rst_count", 32'(WORD_COUNT), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
